// File: rtl/id_exe_reg_pkg.sv
// Purpose : shared widths, bubble constants and control-gating helper for the ID/EX register.
// Latency : n/a (declarations only).
// Backpr. : n/a; freeze/flush handling lives in id_exe_reg.
// Contents: width localparams, control-flag struct, bubble constants, gate_ctrl_flags().
package id_exe_reg_pkg;

  localparam int ADDRESS_LEN         = 32;
  localparam int REGISTER_LEN        = 32;
  localparam int EXECUTE_COMMAND_LEN = 4;
  localparam int SHIFT_OPERAND_LEN   = 12;
  localparam int REGFILE_ADDRESS_LEN = 4;
  localparam int BUBBLE_CNT_LEN      = 16;
  localparam int SIGNED_IMM_LEN      = 24;
  localparam int STATUS_LEN          = 4;

  // One-bit decoded controls that must be zero in a bubble slot.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic wb_enable;
    logic branch_taken;
    logic status_write_enable;
  } ctrl_flags_t;

  localparam int CTRL_FLAG_CNT = $bits(ctrl_flags_t);

  localparam ctrl_flags_t CTRL_FLAGS_BUBBLE = '0;

  // ALU command of a bubble: all zeros, i.e. no operation reaches execute.
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_CMD_BUBBLE = '0;

  // A slot without a real instruction must not produce side effects.
  function automatic ctrl_flags_t gate_ctrl_flags(input ctrl_flags_t flags, input logic valid);
    return valid ? flags : CTRL_FLAGS_BUBBLE;
  endfunction

endpackage

// File: rtl/id_exe_reg_pipe_field_reg.sv
// Purpose : generic field-group register with async clear, hold and synchronous clear.
// Latency : 1 cycle from d_i to q_o.
// Backpr. : hold_i freezes the contents (wins over clr_i); clr_i loads all zeros.
// Ports   : clk_i, rst_ni (async active-low), hold_i, clr_i, d_i[WIDTH], q_o[WIDTH].
module pipe_field_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] field_d;
  logic [WIDTH-1:0] field_q;

  always_comb begin
    field_d = field_q;
    if (!hold_i) begin
      field_d = clr_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      field_q <= '0;
    end else begin
      field_q <= field_d;
    end
  end

  assign q_o = field_q;

endmodule

// File: rtl/id_exe_reg.sv
// Purpose : ID/EX pipeline register of the 5-stage ARM core, with valid flag and bubble counter.
// Latency : exactly 1 cycle, every output is registered.
// Backpr. : freeze holds all state (over flush); flush inserts an all-zero bubble.
// Ports   : clk, rst (async active-low), freeze, flush, valid_in, decoded *_in fields,
//           matching *_out fields, valid_out, bubble_count (saturating squash counter).
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int ADDRESS_LEN         = id_exe_reg_pkg::ADDRESS_LEN,
  parameter int REGISTER_LEN        = id_exe_reg_pkg::REGISTER_LEN,
  parameter int EXECUTE_COMMAND_LEN = id_exe_reg_pkg::EXECUTE_COMMAND_LEN,
  parameter int SHIFT_OPERAND_LEN   = id_exe_reg_pkg::SHIFT_OPERAND_LEN,
  parameter int REGFILE_ADDRESS_LEN = id_exe_reg_pkg::REGFILE_ADDRESS_LEN,
  parameter int BUBBLE_CNT_LEN      = id_exe_reg_pkg::BUBBLE_CNT_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           flush,
  input  logic                           valid_in,
  input  logic [ADDRESS_LEN-1:0]         PC_in,
  input  logic                           mem_read_in,
  input  logic                           mem_write_in,
  input  logic                           wb_enable_in,
  input  logic                           branch_taken_in,
  input  logic                           status_write_enable_in,
  input  logic                           immediate_in,
  input  logic [EXECUTE_COMMAND_LEN-1:0] execute_command_in,
  input  logic [REGISTER_LEN-1:0]        reg_file_out1_in,
  input  logic [REGISTER_LEN-1:0]        reg_file_out2_in,
  input  logic [REGFILE_ADDRESS_LEN-1:0] src1_in,
  input  logic [REGFILE_ADDRESS_LEN-1:0] src2_in,
  input  logic [REGFILE_ADDRESS_LEN-1:0] dest_reg_in,
  input  logic [SIGNED_IMM_LEN-1:0]      signed_immediate_in,
  input  logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_in,
  input  logic [STATUS_LEN-1:0]          status_in,
  output logic                           valid_out,
  output logic [ADDRESS_LEN-1:0]         PC_out,
  output logic                           mem_read_out,
  output logic                           mem_write_out,
  output logic                           wb_enable_out,
  output logic                           branch_taken_out,
  output logic                           status_write_enable_out,
  output logic                           immediate_out,
  output logic [EXECUTE_COMMAND_LEN-1:0] execute_command_out,
  output logic [REGISTER_LEN-1:0]        reg_file_out1_out,
  output logic [REGISTER_LEN-1:0]        reg_file_out2_out,
  output logic [REGFILE_ADDRESS_LEN-1:0] src1_out,
  output logic [REGFILE_ADDRESS_LEN-1:0] src2_out,
  output logic [REGFILE_ADDRESS_LEN-1:0] dest_reg_out,
  output logic [SIGNED_IMM_LEN-1:0]      signed_immediate_out,
  output logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_out,
  output logic [STATUS_LEN-1:0]          status_out,
  output logic [BUBBLE_CNT_LEN-1:0]      bubble_count
);

  localparam int CTRL_W = CTRL_FLAG_CNT + EXECUTE_COMMAND_LEN;
  localparam int DATA_W = ADDRESS_LEN + 2 * REGISTER_LEN + 3 * REGFILE_ADDRESS_LEN
                        + SIGNED_IMM_LEN + SHIFT_OPERAND_LEN + 1;

  // ---------------------------------------------------------------------------
  // Control group: side-effect controls are forced to a bubble when the
  // decode slot is empty, so only real instructions can act in execute.
  // ---------------------------------------------------------------------------
  ctrl_flags_t                    ctrl_flags_in;
  ctrl_flags_t                    ctrl_flags_gated;
  logic [EXECUTE_COMMAND_LEN-1:0] exe_cmd_gated;
  logic [CTRL_W-1:0]              ctrl_d;
  logic [CTRL_W-1:0]              ctrl_q;

  assign ctrl_flags_in    = {mem_read_in, mem_write_in, wb_enable_in,
                             branch_taken_in, status_write_enable_in};
  assign ctrl_flags_gated = gate_ctrl_flags(ctrl_flags_in, valid_in);
  assign exe_cmd_gated    = valid_in ? execute_command_in
                                     : EXECUTE_COMMAND_LEN'(EXE_CMD_BUBBLE);
  assign ctrl_d           = {ctrl_flags_gated, exe_cmd_gated};

  pipe_field_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .hold_i (freeze),
    .clr_i  (flush),
    .d_i    (ctrl_d),
    .q_o    (ctrl_q)
  );

  assign {mem_read_out, mem_write_out, wb_enable_out, branch_taken_out,
          status_write_enable_out, execute_command_out} = ctrl_q;

  // ---------------------------------------------------------------------------
  // Data group: operands, indices and immediates load even for an empty slot;
  // they are harmless without the controls and only cleared by a flush.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  assign data_d = {PC_in, reg_file_out1_in, reg_file_out2_in, src1_in, src2_in,
                   dest_reg_in, signed_immediate_in, shift_operand_in, immediate_in};

  pipe_field_reg #(.WIDTH(DATA_W)) u_data_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .hold_i (freeze),
    .clr_i  (flush),
    .d_i    (data_d),
    .q_o    (data_q)
  );

  assign {PC_out, reg_file_out1_out, reg_file_out2_out, src1_out, src2_out,
          dest_reg_out, signed_immediate_out, shift_operand_out, immediate_out} = data_q;

  // ---------------------------------------------------------------------------
  // Status group: NZCV snapshot at decode (execute consumes the carry).
  // ---------------------------------------------------------------------------
  pipe_field_reg #(.WIDTH(STATUS_LEN)) u_status_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .hold_i (freeze),
    .clr_i  (flush),
    .d_i    (status_in),
    .q_o    (status_out)
  );

  // ---------------------------------------------------------------------------
  // Valid flag and saturating bubble counter. The counter only counts real
  // instructions squashed by a flush; a frozen edge never counts, even if
  // flush is high, because the branch is still in execute and will re-flush.
  // ---------------------------------------------------------------------------
  logic                      valid_d;
  logic                      valid_q;
  logic [BUBBLE_CNT_LEN-1:0] bubble_cnt_d;
  logic [BUBBLE_CNT_LEN-1:0] bubble_cnt_q;

  always_comb begin
    valid_d      = valid_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!freeze) begin
      if (flush) begin
        valid_d = 1'b0;
        if (valid_in && (bubble_cnt_q != '1)) begin
          bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_LEN'(1);
        end
      end else begin
        valid_d = valid_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_out    = valid_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM core. It captures every decoded control signal, operand value and immediate field produced by decode on each clock. It supports freeze (hold) for memory stalls and flush (bubble insertion) when the execute stage resolves a taken branch. It also keeps a valid flag and a saturating bubble counter for debug and performance visibility.

## Interface
Parameters:
- ADDRESS_LEN, 32, PC width
- REGISTER_LEN, 32, register data width
- EXECUTE_COMMAND_LEN, 4, ALU command width
- SHIFT_OPERAND_LEN, 12, shifter-operand width
- REGFILE_ADDRESS_LEN, 4, register index width
- BUBBLE_CNT_LEN, 16, bubble counter width

Ports (all `_in` inputs have a matching `_out` output of the same width, registered):
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold all state this cycle
- flush  in  1  replace the incoming instruction with a bubble
- valid_in  in  1  decode slot holds a real instruction
- PC_in  in  ADDRESS_LEN  PC of the decoded instruction
- mem_read_in, mem_write_in, wb_enable_in, branch_taken_in, status_write_enable_in, immediate_in  in  1 each  decoded controls
- execute_command_in  in  EXECUTE_COMMAND_LEN  ALU command
- reg_file_out1_in, reg_file_out2_in  in  REGISTER_LEN  operand values Rn and Rm/Rd
- src1_in, src2_in  in  REGFILE_ADDRESS_LEN  source register indices (for forwarding)
- dest_reg_in  in  REGFILE_ADDRESS_LEN  Rd
- signed_immediate_in  in  24  branch offset
- shift_operand_in  in  SHIFT_OPERAND_LEN  shifter operand
- status_in  in  4  NZCV at decode time (carry used by execute)
- valid_out  out  1  execute slot holds a real instruction
- bubble_count  out  BUBBLE_CNT_LEN  number of flush-inserted bubbles, saturating

## Operation
- **Reset** (rst=0, asynchronous, any time):
  - every `_out`, valid_out and bubble_count go to 0 immediately.
  - The outputs stay 0 while rst is low.
  - An all-zero slot is a legal bubble: no memory access, no writeback, no status write, no branch.
- **Rising edge, priority freeze > flush > load:**
  - freeze=1: all registers hold, including valid_out and bubble_count. flush is ignored. The branching instruction remains in execute, so flush re-asserts after the freeze drops.
  - freeze=0, flush=1:
    - Control fields mem_read, mem_write, wb_enable, branch_taken, status_write_enable and execute_command are cleared to 0.
    - valid_out is cleared to 0.
    - Data fields (PC, operands, indices, immediates, status) are also cleared to 0.
    - bubble_count increments by 1 if valid_in=1 (a real instruction was squashed). At all-ones it stays all-ones.
  - freeze=0, flush=0: every `_out` takes its `_in`, and valid_out takes valid_in.
    - If valid_in=0, the control fields are forced to 0 regardless of their inputs. The data fields still load.
- **Width rules:** no arithmetic except bubble_count (unsigned, saturating). All fields are carried bit-exact.

## Timing
- Latency is exactly 1 cycle from `_in` at edge N to `_out` after edge N.
- There is no combinational path from any input to any output.
- freeze and flush are sampled only at the rising edge. A pulse between edges has no effect.
- Simultaneous freeze=1 and flush=1 means hold, with no count.
- Back-to-back flushes give consecutive bubbles. The count increments once per edge with valid_in=1.
- If reset is asserted mid-freeze, outputs clear at once. After release, the first edge performs a normal load/flush/freeze per its inputs.

## Structure
- Shared package/defines holds:
  - the width constants ADDRESS_LEN, REGISTER_LEN, EXECUTE_COMMAND_LEN, SHIFT_OPERAND_LEN, REGFILE_ADDRESS_LEN
  - a bubble constant for execute_command (all zeros).
- One natural sub-module: `pipe_field_reg`, a parameterised-width register with async active-low clear, hold enable and synchronous clear. Instantiate it once per field group: control, data and status.
- The bubble counter and valid flag are implemented locally.

## Test plan
1. **Reset:** drive all inputs to nonzero, pulse rst=0 mid-cycle -> every output reads 0 before the next edge, and bubble_count=0.
2. **Load:** valid_in=1, PC_in=0x00000010, execute_command_in=4'b0010, wb_enable_in=1, reg_file_out1_in=0x0000000D, dest_reg_in=4'd7; one edge -> the same values appear on `_out`, and valid_out=1.
3. **Freeze:**
   - Load as in test 2, then change all inputs and hold freeze=1 for 3 edges -> outputs unchanged for 3 cycles.
   - Assert flush=1 during the freeze as well -> outputs still unchanged, and bubble_count unchanged.
4. **Flush:** valid_in=1, mem_write_in=1, wb_enable_in=1, flush=1; one edge -> all controls 0, valid_out=0, bubble_count=1. Repeat for 2 more edges -> bubble_count=3.
5. **Invalid slot:** valid_in=0, wb_enable_in=1, mem_read_in=1, reg_file_out2_in=0xFFFFFFFF -> wb_enable_out=0, mem_read_out=0, reg_file_out2_out=0xFFFFFFFF, valid_out=0.
6. **Saturation:** with BUBBLE_CNT_LEN=4, apply 20 flush edges with valid_in=1 -> bubble_count stops at 4'hF.
